// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch path: FSM state encoding and parameter defaults.
package bitty_pkg;

    localparam int          ADDR_W_DEF  = 8;
    localparam logic [15:0] HALT_OP_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        HALTED
    } state_t;

endpackage

// File: rtl/imem.sv
// Instruction memory: 2^ADDR_W x 16 words, one synchronous write port, one synchronous read port.
// Contents are intentionally never reset so a program survives a core reset.
module imem import bitty_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem [DEPTH];

    // Write and registered read share the edge; the fetch FSM never overlaps them on one address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: sequences instruction reads from imem, presents them to the core,
// follows branches reported on done, and stops on the halt opcode.
module fetch_unit import bitty_pkg::*; #(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter logic [15:0] HALT_OP = HALT_OP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              done,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              load_err
);

    state_t      state;
    logic [15:0] instruction_q;
    logic [15:0] rd_data;
    logic        load_window;
    logic        mem_wr_en;
    logic        mem_rd_en;

    // Loads are only accepted while the FSM is parked, so no read can race a write.
    assign load_window = (state == IDLE) || (state == HALTED);
    assign mem_wr_en   = load_en && load_window;
    assign mem_rd_en   = (state == FETCH);

    imem #(.ADDR_W(ADDR_W)) u_imem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (mem_rd_en),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    // In ISSUE the freshly read word is shown directly so inst_valid lands two cycles after start/done;
    // afterwards the captured copy keeps the word stable while the core works.
    assign instruction = (state == ISSUE) ? rd_data : instruction_q;
    assign inst_valid  = (state == ISSUE) && (rd_data != HALT_OP);
    assign busy        = (state == FETCH) || (state == ISSUE) || (state == WAIT);
    assign halted      = (state == HALTED);

    // Main FSM with pc, instruction capture and dropped-load reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= '0;
            instruction_q <= 16'h0000;
            load_err      <= 1'b0;
        end else begin
            load_err <= load_en && !load_window;
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (start && !load_en) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    instruction_q <= rd_data;
                    state         <= (rd_data == HALT_OP) ? HALTED : WAIT;
                end
                WAIT: begin
                    if (done) begin
                        pc    <= branch_valid ? branch_target : pc + 1'b1;
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (start && !load_en) begin
                        pc    <= '0;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        done;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic [15:0] instruction;
    logic        inst_valid;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        load_err;

    int totalChecks  = 0;
    int passedChecks = 0;
    int pulseCount;
    logic [15:0] heldInstruction;

    fetch_unit #(.ADDR_W(8), .HALT_OP(16'hFFFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .done          (done),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instruction   (instruction),
        .inst_valid    (inst_valid),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic ld, input logic [7:0] la, input logic [15:0] shortData,
                                 input logic dn, input logic bv, input logic [7:0] bt);
        start         = st;
        load_en       = ld;
        load_addr     = la;
        load_data     = shortData;
        done          = dn;
        branch_valid  = bv;
        branch_target = bt;
        stepClock();
        start        = 1'b0;
        load_en      = 1'b0;
        done         = 1'b0;
        branch_valid = 1'b0;
    endtask

    task automatic loadWord(input logic [7:0] a, input logic [15:0] d);
        applyStimulus(1'b0, 1'b1, a, d, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        done = 1'b0; branch_valid = 1'b0; branch_target = '0;
        stepClock();
        stepClock();
        checkOutput("reset_instruction", 32'(instruction), 32'h0000);
        checkOutput("reset_pc", 32'(pc), 32'h00);
        checkOutput("reset_flags", {28'h0, inst_valid, busy, halted, load_err}, 32'h0);
        reset = 1'b1;
        stepClock();

        loadWord(8'h00, 16'h1234);
        loadWord(8'h01, 16'h5678);
        loadWord(8'h02, 16'hFFFF);
        loadWord(8'h40, 16'hABCD);
        loadWord(8'hFF, 16'h0F0F);
        checkOutput("load_idle_no_err", 32'(load_err), 32'h0);
        checkOutput("load_idle_not_busy", 32'(busy), 32'h0);

        // start -> FETCH -> ISSUE
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00);
        checkOutput("fetch_busy", 32'(busy), 32'h1);
        checkOutput("fetch_no_valid", 32'(inst_valid), 32'h0);
        stepClock();
        checkOutput("issue0_valid", 32'(inst_valid), 32'h1);
        checkOutput("issue0_instr", 32'(instruction), 32'h1234);
        checkOutput("issue0_pc", 32'(pc), 32'h00);

        // hold in WAIT for 10 cycles without done
        pulseCount = 0;
        heldInstruction = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            stepClock();
            if (inst_valid) pulseCount++;
        end
        checkOutput("wait_no_extra_pulse", 32'(pulseCount), 32'h0);
        checkOutput("wait_instr_stable", 32'(instruction), 32'(heldInstruction));
        checkOutput("wait_pc_stable", 32'(pc), 32'h00);

        // dropped write and ignored start during WAIT
        loadWord(8'h01, 16'hDEAD);
        checkOutput("wait_load_err", 32'(load_err), 32'h1);
        stepClock();
        checkOutput("wait_load_err_pulse_end", 32'(load_err), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00);
        stepClock();
        checkOutput("wait_start_ignored_pc", 32'(pc), 32'h00);
        checkOutput("wait_start_ignored_busy", {30'h0, busy, inst_valid}, 32'h2);

        // done -> next sequential instruction, readback proves write was dropped
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("done_fetch_no_valid", 32'(inst_valid), 32'h0);
        stepClock();
        checkOutput("issue1_valid", 32'(inst_valid), 32'h1);
        checkOutput("issue1_instr", 32'(instruction), 32'h5678);
        checkOutput("issue1_pc", 32'(pc), 32'h01);
        stepClock();

        // done -> halt opcode
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h00);
        stepClock();
        checkOutput("halt_issue_no_valid", 32'(inst_valid), 32'h0);
        stepClock();
        checkOutput("halted_flags", {29'h0, halted, busy, inst_valid}, 32'h4);
        checkOutput("halted_pc", 32'(pc), 32'h02);

        // restart from HALTED, branch to 0x40
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00);
        checkOutput("restart_pc0", 32'(pc), 32'h00);
        stepClock();
        checkOutput("restart_instr", 32'(instruction), 32'h1234);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h40);
        stepClock();
        checkOutput("branch_pc", 32'(pc), 32'h40);
        checkOutput("branch_instr", 32'(instruction), 32'hABCD);
        checkOutput("branch_valid_pulse", 32'(inst_valid), 32'h1);
        stepClock();

        // branch to 0xFF, then sequential wrap to 0x00
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'hFF);
        stepClock();
        checkOutput("top_pc", 32'(pc), 32'hFF);
        checkOutput("top_instr", 32'(instruction), 32'h0F0F);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h77);
        stepClock();
        checkOutput("wrap_pc", 32'(pc), 32'h00);
        checkOutput("wrap_instr", 32'(instruction), 32'h1234);
        checkOutput("wrap_valid", 32'(inst_valid), 32'h1);
        stepClock();

        // reset asserted while in FETCH
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h00);
        checkOutput("pre_reset_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_pc", 32'(pc), 32'h00);
        checkOutput("async_reset_instr", 32'(instruction), 32'h0000);
        checkOutput("async_reset_flags", {28'h0, inst_valid, busy, halted, load_err}, 32'h0);
        stepClock();
        checkOutput("reset_no_pulse", 32'(inst_valid), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("release_hold_flags", {28'h0, inst_valid, busy, halted, load_err}, 32'h0);
        stepClock();

        // simultaneous start and load in IDLE: write wins, start deferred
        applyStimulus(1'b1, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 8'h00);
        checkOutput("start_deferred", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00);
        stepClock();
        checkOutput("mem_preserved", 32'(instruction), 32'h1234);
        checkOutput("mem_preserved_valid", 32'(inst_valid), 32'h1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h05);
        stepClock();
        checkOutput("deferred_write_landed", 32'(instruction), 32'h5555);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
